// File: rtl/score_bcd_formatter_if.sv
// score_bcd_formatter_if
//   Bundles the score inputs, the update/busy/done handshake and the
//   seven-segment digit outputs of score_bcd_formatter.
//   master : drives left_score, right_score, update; receives results.
//   slave  : the formatter side.
interface score_bcd_formatter_if #(
  parameter int SCORE_BITS = 7
);
  logic [SCORE_BITS-1:0] left_score;
  logic [SCORE_BITS-1:0] right_score;
  logic                  update;
  logic                  busy;
  logic                  done;
  logic [15:0]           data_out;
  logic [3:0]            digit_display;
  logic [3:0]            digit_point;

  modport master (
    output left_score, right_score, update,
    input  busy, done, data_out, digit_display, digit_point
  );

  modport slave (
    input  left_score, right_score, update,
    output busy, done, data_out, digit_display, digit_point
  );
endinterface

// File: rtl/score_bcd_formatter.sv
// score_bcd_formatter
//   Converts two binary player scores into four BCD digits for the pong
//   seven-segment controller using a 7-iteration double-dabble engine.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-low reset
//     bus   - score_bcd_formatter_if.slave: scores + update request in;
//             busy, done pulse, data_out digits, digit_display enables and
//             digit_point separators out (all registered).
module score_bcd_formatter #(
  parameter int SCORE_BITS = 7,
  parameter int SCORE_MAX  = 99,
  parameter int SEP_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  score_bcd_formatter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  localparam logic [SCORE_BITS-1:0] MAX_V  = SCORE_BITS'(SCORE_MAX);
  localparam logic [6:0]            MAX_7  = 7'(SCORE_MAX);
  localparam logic [3:0]            DP_V   = {1'b0, (SEP_EN != 0), 2'b00};

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic        pending_r;
  logic        busy_r;
  logic        done_r;
  // {tens, units, binary} working registers, one per player
  logic [14:0] sh_l_r;
  logic [14:0] sh_r_r;
  logic [15:0] data_r;
  logic [3:0]  disp_r;
  logic [3:0]  dp_r;

  // The clamp keeps every captured score within two decimal digits, so
  // only the low 7 bits are ever needed by the engine.
  function automatic logic [6:0] clamp7(input logic [SCORE_BITS-1:0] s);
    logic [SCORE_BITS-1:0] c;
    c = (s > MAX_V) ? MAX_V : s;
    return c[6:0];
  endfunction

  // One double-dabble step: adjust each BCD nibble >= 5 by +3, then shift.
  function automatic logic [14:0] dabble(input logic [14:0] r);
    logic [14:0] t;
    t = r;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      pending_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      sh_l_r    <= 15'd0;
      sh_r_r    <= 15'd0;
      data_r    <= 16'h0000;
      disp_r    <= 4'b0101;
      dp_r      <= DP_V;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A request landing on the FINISH edge without a restart is
          // parked in pending and honoured here on the next edge.
          if (bus.update || pending_r) begin
            sh_l_r    <= {8'h00, clamp7(bus.left_score)};
            sh_r_r    <= {8'h00, clamp7(bus.right_score)};
            cnt_r     <= 3'd0;
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= CONVERT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        CONVERT: begin
          sh_l_r <= dabble(sh_l_r);
          sh_r_r <= dabble(sh_r_r);
          if (bus.update) pending_r <= 1'b1;
          if (cnt_r == 3'd6) begin
            cnt_r   <= 3'd0;
            state_r <= FINISH;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        FINISH: begin
          data_r <= {sh_l_r[14:7], sh_r_r[14:7]};
          disp_r <= {(sh_l_r[14:11] != 4'd0), 1'b1,
                     (sh_r_r[14:11] != 4'd0), 1'b1};
          dp_r   <= DP_V;
          done_r <= 1'b1;
          if (pending_r) begin
            // Restart captures the scores as they are now, which also
            // satisfies any request arriving on this same edge.
            sh_l_r    <= {8'h00, clamp7(bus.left_score)};
            sh_r_r    <= {8'h00, clamp7(bus.right_score)};
            cnt_r     <= 3'd0;
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= CONVERT;
          end else begin
            pending_r <= bus.update;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 3'd0;
          pending_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.data_out      = data_r;
  assign bus.digit_display = disp_r;
  assign bus.digit_point   = dp_r;

endmodule

// File: tb/tb_score_bcd_formatter.sv
// tb_score_bcd_formatter
//   Randomized and directed stimulus for score_bcd_formatter, checked every
//   cycle against a transaction-level model that counts edges to completion
//   and formats scores with decimal arithmetic.
module tb_score_bcd_formatter;

  logic clk;
  logic reset;

  score_bcd_formatter_if #(.SCORE_BITS(7)) bus ();

  score_bcd_formatter #(
    .SCORE_BITS(7),
    .SCORE_MAX (99),
    .SEP_EN    (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt;
  int err_cnt;

  // reference model state
  bit        m_active;
  int        m_left;
  bit        m_pend;
  int        m_cl;
  int        m_cr;
  logic [15:0] e_data;
  logic [3:0]  e_disp;
  logic        e_done;
  logic        e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int clampm(input int s);
    return (s > 99) ? 99 : s;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_left   = 0;
    m_pend   = 1'b0;
    e_data   = 16'h0000;
    e_disp   = 4'b0101;
    e_done   = 1'b0;
    e_busy   = 1'b0;
  endtask

  task automatic model_capture(input int l, input int r);
    m_cl     = clampm(l);
    m_cr     = clampm(r);
    m_left   = 8;
    m_active = 1'b1;
    m_pend   = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_edge(input bit upd, input int l, input int r);
    e_done = 1'b0;
    if (!m_active) begin
      if (upd || m_pend) model_capture(l, r);
    end else begin
      m_left--;
      if (m_left == 0) begin
        e_data = 16'((m_cl / 10) << 12) | 16'((m_cl % 10) << 8) |
                 16'((m_cr / 10) << 4)  | 16'(m_cr % 10);
        e_disp = {(m_cl >= 10), 1'b1, (m_cr >= 10), 1'b1};
        e_done = 1'b1;
        if (m_pend) begin
          model_capture(l, r);
        end else begin
          m_active = 1'b0;
          m_pend   = upd;
        end
      end else if (upd) begin
        m_pend = 1'b1;
      end
    end
    e_busy = m_active;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, 32'(bus.data_out), 32'(e_data));
    chk({tag, ".disp"}, 32'(bus.digit_display), 32'(e_disp));
    chk({tag, ".dp"},   32'(bus.digit_point), 32'h4);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(e_busy));
    chk({tag, ".done"}, 32'(bus.done), 32'(e_done));
  endtask

  // Drive inputs at the falling edge, clock once, check at the next falling edge.
  task automatic cycle(input string tag, input bit upd, input int l, input int r);
    bus.update      = upd;
    bus.left_score  = 7'(l);
    bus.right_score = 7'(r);
    model_edge(upd, l, r);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  int done_seen;

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    bus.update      = 1'b0;
    bus.left_score  = 7'd0;
    bus.right_score = 7'd0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("rst");
    reset = 1'b1;

    for (int i = 0; i < 20; i++) cycle("idle", 1'b0, 0, 0);

    // 42 / 7 single request; also verify done latency directly
    cycle("s42", 1'b1, 42, 7);
    done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle("s42w", 1'b0, 42, 7);
      if (bus.done) begin
        done_seen++;
        chk("lat42", 32'(i), 32'd8);
      end
    end
    chk("ndone42", 32'(done_seen), 32'd1);
    chk("val42", 32'(bus.data_out), 32'h4207);

    // clamp then two-digit values
    cycle("s120", 1'b1, 120, 0);
    for (int i = 0; i < 9; i++) cycle("s120w", 1'b0, 120, 0);
    chk("val120", 32'(bus.data_out), 32'h9900);
    cycle("s10", 1'b1, 10, 99);
    for (int i = 0; i < 9; i++) cycle("s10w", 1'b0, 10, 99);
    chk("val10", 32'(bus.data_out), 32'h1099);

    // collapse of two mid-conversion requests into one restart
    cycle("p35", 1'b1, 3, 5);
    cycle("p35a", 1'b0, 8, 11);
    cycle("p35b", 1'b1, 8, 11);
    cycle("p35c", 1'b0, 8, 11);
    cycle("p35d", 1'b1, 8, 11);
    done_seen = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("p35w", 1'b0, 8, 11);
      if (bus.done) done_seen++;
    end
    chk("ndone_p", 32'(done_seen), 32'd2);
    chk("val811", 32'(bus.data_out), 32'h0811);

    // reset mid-conversion
    cycle("r77", 1'b1, 77, 66);
    for (int i = 0; i < 3; i++) cycle("r77w", 1'b0, 77, 66);
    reset = 1'b0;
    model_reset();
    #1;
    check_all("rasync");
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check_all("rhold");
    end
    reset = 1'b1;
    cycle("r12", 1'b1, 1, 2);
    for (int i = 0; i < 12; i++) cycle("r12w", 1'b0, 1, 2);
    chk("val12", 32'(bus.data_out), 32'h0102);
    chk("disp12", 32'(bus.digit_display), 32'h5);

    // update held high with changing scores
    for (int i = 0; i < 40; i++)
      cycle("hold", 1'b1, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
    for (int i = 0; i < 20; i++) cycle("holdw", 1'b0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", ($urandom_range(0, 3) == 0), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 127)));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/score_bcd_formatter.md
# score_bcd_formatter

Sequential formatter feeding the four-digit seven-segment controller in the pong design. Takes the two binary player scores and converts each to two BCD digits with an iterative shift-add-3 (double-dabble) engine. Registers the result as the controller's 16-bit digit word, digit-enable mask and decimal-point mask. Updates are requested by a one-cycle pulse, and completion is reported with a done pulse.

## Interface
- `SCORE_BITS`, default 7: width of each binary score input.
- `SCORE_MAX`, default 99: clamp value; captured scores above this are replaced by it.
- `SEP_EN`, default 1: when 1, the decimal point after the left units digit is lit as the score separator.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; 0 forces all state to reset values immediately.
- `left_score` input SCORE_BITS: left player score, unsigned.
- `right_score` input SCORE_BITS: right player score, unsigned.
- `update` input 1: request a conversion; sampled every rising edge.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse; outputs are newly valid.
- `data_out` output 16: BCD digits, assigned as follows:
  - [15:12] left tens
  - [11:8] left units
  - [7:4] right tens
  - [3:0] right units
- `digit_display` output 4: per-digit enable, 1 = lit, bit 3 = leftmost.
- `digit_point` output 4: per-digit decimal point, 1 = lit.

## Operation
- States:
  - IDLE: waiting for a request.
  - CONVERT: 7 iterations, one per cycle, counter 0..6.
  - FINISH: loads the outputs.
- IDLE, `update`=1:
  - Capture both scores; any value >`SCORE_MAX` is clamped to `SCORE_MAX`.
  - Load two shift registers, each {8-bit BCD = 0, 7-bit binary}.
  - Counter = 0; go to CONVERT.
- CONVERT iteration, both scores in parallel:
  - Each BCD nibble ≥5 gets +3.
  - Then the whole register shifts left 1.
  - After the iteration with counter = 6, go to FINISH.
- FINISH:
  - Register `data_out` from both BCD results.
  - `digit_display` = {left_tens≠0, 1, right_tens≠0, 1}; the tens digit is leading-zero blanked, the units digit is always lit.
  - `digit_point` = {0, `SEP_EN`, 0, 0}.
  - `done`=1 for the following cycle.
  - If `pending`=1: clear it, capture the current inputs and go to CONVERT. Otherwise go to IDLE.
- `update`=1 while in CONVERT or FINISH sets `pending`. Multiple requests collapse into one. Scores are captured at restart, not at request time.
- `data_out`, `digit_display` and `digit_point` change only in the cycle `done` is asserted. They hold between conversions, so the downstream display never sees partial digits.
- Arithmetic: every nibble is 0–9 after each shift. SCORE_BITS > 7 is allowed; the clamp guarantees two digits.

## Timing
- Reset values:
  - State IDLE, counter 0, `pending` 0, `busy` 0, `done` 0.
  - `data_out` 16'h0000, `digit_display` 4'b0101, `digit_point` {0,`SEP_EN`,0,0}.
- Edge E0 samples `update`=1 in IDLE.
  - `busy`=1 in the cycles following E0 through E7 (8 cycles).
  - CONVERT iterations occur on E1..E7.
  - E8 loads the outputs. `done`=1 and new outputs are visible in the cycle after E8, and `busy`=0 in that cycle unless a pending restart occurs.
- Latency from request to `done` is 8 edges. Throughput with `update` held high is one `done` every 8 cycles.
- Pending restart: `busy` stays 1 through E8; the next `done` follows E16.
- `busy` is 0 and `done` is 0 in every IDLE cycle. `done` is never high for two consecutive cycles.
- Reset asserted mid-operation: all state returns to reset values asynchronously, any pending request is discarded, and no `done` is produced for the aborted conversion.
- `update` on the first edge after reset release is accepted normally.

## Test plan
- Reset, then idle 20 cycles: `data_out`=16'h0000, `digit_display`=4'b0101, `digit_point`=4'b0100 (`SEP_EN`=1), `busy`=0, `done`=0 throughout.
- Left=42, right=7, one `update` pulse:
  - `busy` high for exactly 8 cycles.
  - `done` high for 1 cycle, 8 edges after the request.
  - `data_out`=16'h4207, `digit_display`=4'b1101.
- Left=120 (clamp), right=0: `data_out`=16'h9900, `digit_display`=4'b1101. Then left=10, right=99: `data_out`=16'h1099, `digit_display`=4'b1111.
- Request with 3/5, then `update` pulses twice mid-conversion while the inputs change to 8/11:
  - First `done` shows 16'h0305.
  - Exactly one more `done`, 8 cycles later, shows 16'h0811.
  - `busy` stays continuously high between the two `done` pulses.
- Start with 77/66, assert `reset` low at the 4th CONVERT cycle for 2 cycles, then release:
  - Outputs at reset values immediately.
  - No `done` pulse.
  - A new request with 1/2 yields 16'h0102, `digit_display`=4'b0101.
- `update` held high for 40 cycles: `done` every 8 cycles, never on consecutive cycles, `data_out` always matching the current scores.
